// File: rtl/mips_mem_pkg.sv
// Shared definitions for the IF/DM memory arbiter: address map defaults,
// access-size encodings, beat lookup and the sequencer state type.
package mips_mem_pkg;

  localparam logic [31:0] START_ADDR_DEF = 32'h8002_0000;
  localparam int unsigned MEM_BYTES_DEF  = 1024;

  // mips_memory2 access_size encodings
  localparam logic [2:0] SZ_WORD = 3'b000;
  localparam logic [2:0] SZ_4W   = 3'b001;
  localparam logic [2:0] SZ_8W   = 3'b010;
  localparam logic [2:0] SZ_16W  = 3'b011;
  localparam logic [2:0] SZ_BYTE = 3'b100;
  localparam logic [2:0] SZ_HALF = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_ERR
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  // Number of data beats the memory returns for a read of the given size;
  // illegal sizes report zero.
  function automatic logic [4:0] beats(input logic [2:0] size);
    logic [4:0] n;
    unique case (size)
      SZ_WORD: n = 5'd1;
      SZ_4W:   n = 5'd4;
      SZ_8W:   n = 5'd8;
      SZ_16W:  n = 5'd16;
      SZ_BYTE: n = 5'd1;
      SZ_HALF: n = 5'd1;
      default: n = 5'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mips_mem_range_chk.sv
// Combinational legality check for one memory request: size encoding,
// natural alignment, full containment in the memory window, and no burst
// writes. Also reports the number of bytes the access touches.
module mips_mem_range_chk
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] START_ADDR = START_ADDR_DEF,
  parameter int unsigned MEM_BYTES  = MEM_BYTES_DEF
) (
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  input  logic        i_rw,
  output logic        o_err,
  output logic [6:0]  o_nbytes
);

  // One past the last valid byte, widened so the sum cannot wrap.
  localparam logic [32:0] LIMIT = {1'b0, START_ADDR} + 33'(MEM_BYTES);

  logic [6:0]  w_nbytes;
  logic        w_bad_size;
  logic        w_misalign;
  logic        w_out_of_range;
  logic        w_write_burst;
  logic [32:0] w_end;

  // Decode size into byte count and evaluate each fault condition.
  always_comb begin
    w_nbytes   = '0;
    w_bad_size = 1'b0;
    w_misalign = 1'b0;
    unique case (i_size)
      SZ_WORD: begin w_nbytes = 7'd4;  w_misalign = (i_addr[1:0] != 2'b00); end
      SZ_4W:   begin w_nbytes = 7'd16; w_misalign = (i_addr[1:0] != 2'b00); end
      SZ_8W:   begin w_nbytes = 7'd32; w_misalign = (i_addr[1:0] != 2'b00); end
      SZ_16W:  begin w_nbytes = 7'd64; w_misalign = (i_addr[1:0] != 2'b00); end
      SZ_BYTE: begin w_nbytes = 7'd1; end
      SZ_HALF: begin w_nbytes = 7'd2;  w_misalign = i_addr[0]; end
      default: begin w_bad_size = 1'b1; end
    endcase

    w_end          = {1'b0, i_addr} + 33'(w_nbytes);
    w_out_of_range = (i_addr < START_ADDR) || (w_end > LIMIT);
    w_write_burst  = i_rw && ((i_size == SZ_4W) || (i_size == SZ_8W) || (i_size == SZ_16W));
  end

  assign o_nbytes = w_nbytes;
  assign o_err    = w_bad_size | w_misalign | w_out_of_range | w_write_burst;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter/sequencer sharing one mips_memory2 port between instruction fetch
// and the data-memory stage. DM has priority, bounded by a streak limit so
// a waiting IF request is eventually served. Requests are checked before
// any memory access; read bursts are counted beat by beat and data is
// passed straight through to the winner.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] START_ADDR    = START_ADDR_DEF,
  parameter int unsigned MEM_BYTES     = MEM_BYTES_DEF,
  parameter int unsigned DM_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch (read only)
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic [2:0]  if_size,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  // data memory stage
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_size,
  input  logic        dm_rw,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_err,
  // memory port
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [2:0]  mem_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic [31:0] mem_dout,
  input  logic        mem_busy
);

  localparam logic [2:0] STREAK_MAX = 3'(DM_STREAK_MAX);

  state_e      r_state;
  state_e      w_next;
  owner_e      r_owner;
  logic [2:0]  r_streak;
  logic [4:0]  r_beats;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_size;
  logic        r_rw;

  logic        w_any;
  logic        w_dm_win;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [2:0]  w_sel_size;
  logic        w_sel_rw;
  logic        w_chk_err;
  logic [6:0]  w_chk_nbytes;
  logic        w_last_beat;

  logic        w_gnt;
  logic        w_rvalid;
  logic        w_done;
  logic        w_err;
  logic        w_to_if;

  // Arbitration: DM wins unless IF is also waiting and DM has used up its streak.
  assign w_any    = if_req | dm_req;
  assign w_dm_win = dm_req & (~if_req | (r_streak != STREAK_MAX));

  assign w_sel_addr  = w_dm_win ? dm_addr : if_addr;
  assign w_sel_size  = w_dm_win ? dm_size : if_size;
  assign w_sel_rw    = w_dm_win & dm_rw;
  assign w_sel_wdata = w_dm_win ? dm_wdata : '0;

  mips_mem_range_chk #(
    .START_ADDR (START_ADDR),
    .MEM_BYTES  (MEM_BYTES)
  ) u_chk (
    .i_addr   (w_sel_addr),
    .i_size   (w_sel_size),
    .i_rw     (w_sel_rw),
    .o_err    (w_chk_err),
    .o_nbytes (w_chk_nbytes)
  );

  assign w_last_beat = (r_beats <= 5'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and the owner-agnostic handshake/memory-enable outputs.
  always_comb begin
    w_next     = r_state;
    w_gnt      = 1'b0;
    w_rvalid   = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    mem_enable = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = w_chk_err ? ST_ERR : ST_ISSUE;
      end
      ST_ISSUE: begin
        w_gnt      = 1'b1;
        mem_enable = ~mem_busy;
        if (!mem_busy) w_next = ST_XFER;
      end
      ST_XFER: begin
        // Writes spend a single XFER cycle here purely to pulse done.
        w_rvalid = ~r_rw;
        w_done   = w_last_beat;
        if (w_last_beat) w_next = ST_IDLE;
      end
      ST_ERR: begin
        w_gnt  = 1'b1;
        w_done = 1'b1;
        w_err  = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, streak tracking and beat counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= OWN_IF;
      r_streak <= '0;
      r_beats  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_size   <= '0;
      r_rw     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_dm_win ? OWN_DM : OWN_IF;
            r_addr  <= w_sel_addr;
            r_size  <= w_sel_size;
            r_rw    <= w_sel_rw;
            r_wdata <= w_sel_wdata;
          end
          if (!if_req || !w_dm_win) begin
            r_streak <= '0;
          end else if (r_streak != STREAK_MAX) begin
            r_streak <= r_streak + 3'd1;
          end
        end
        ST_ISSUE: begin
          if (!mem_busy) r_beats <= r_rw ? 5'd1 : beats(r_size);
        end
        ST_XFER: begin
          r_beats <= r_beats - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_to_if = (r_owner == OWN_IF);

  assign if_gnt    = w_gnt    &  w_to_if;
  assign if_rvalid = w_rvalid &  w_to_if;
  assign if_done   = w_done   &  w_to_if;
  assign if_err    = w_err    &  w_to_if;
  assign dm_gnt    = w_gnt    & ~w_to_if;
  assign dm_rvalid = w_rvalid & ~w_to_if;
  assign dm_done   = w_done   & ~w_to_if;
  assign dm_err    = w_err    & ~w_to_if;

  assign if_rdata = if_rvalid ? mem_dout : '0;
  assign dm_rdata = dm_rvalid ? mem_dout : '0;

  assign mem_addr = r_addr;
  assign mem_din  = r_wdata;
  assign mem_size = r_size;
  assign mem_rw   = r_rw;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(if_gnt && dm_gnt));
  a_no_collide: assert property (@(posedge clk) disable iff (!rst_n) mem_enable |-> !mem_busy);
  a_legal_len:  assert property (@(posedge clk) disable iff (!rst_n)
                                 (r_state == ST_IDLE && w_any) |-> (w_chk_err || w_chk_nbytes != '0));

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter with a behavioural mips_memory2
// stand-in and a reference model of request legality, timing and data.
module tb_mips_mem_arbiter;

  localparam logic [31:0] START = 32'h8002_0000;

  logic        clk;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid, if_done, if_err;
  logic [31:0] if_addr, if_rdata;
  logic [2:0]  if_size;
  logic        dm_req, dm_rw, dm_gnt, dm_rvalid, dm_done, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_size;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [2:0]  mem_size;
  logic        mem_rw, mem_enable, mem_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [0:255];

  mips_mem_arbiter #(
    .START_ADDR    (START),
    .MEM_BYTES     (1024),
    .DM_STREAK_MAX (4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_size(if_size),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size), .dm_rw(dm_rw),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_size(mem_size), .mem_rw(mem_rw),
    .mem_enable(mem_enable), .mem_dout(mem_dout), .mem_busy(mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 0) return 32'h3C01_8002;
    return 32'h1234_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  function automatic int unsigned size_beats(input logic [2:0] s);
    case (s)
      3'd1: return 4;
      3'd2: return 8;
      3'd3: return 16;
      3'd0, 3'd4, 3'd5: return 1;
      default: return 0;
    endcase
  endfunction

  // Memory stand-in: accepts on enable & !busy, returns one word per cycle
  // starting the cycle after acceptance, busy while further beats remain.
  logic [31:0] mem [0:255];
  logic [31:0] m_dout;
  logic [4:0]  m_rem;
  logic [7:0]  m_ptr;
  assign mem_dout = m_dout;
  assign mem_busy = (m_rem != 5'd0);

  initial begin : mem_model
    logic [7:0] idx;
    int unsigned nb;
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    m_dout = '0;
    m_rem  = '0;
    m_ptr  = '0;
    forever begin
      @(posedge clk);
      idx = 8'((mem_addr - START) >> 2);
      if (mem_enable && !mem_busy) begin
        if (mem_rw) mem[idx] <= mem_din;
        else begin
          nb = size_beats(mem_size);
          if (nb == 0) nb = 1;
          m_dout <= mem[idx];
          m_ptr  <= idx + 8'd1;
          m_rem  <= 5'(nb - 1);
        end
      end else if (m_rem != 5'd0) begin
        m_dout <= mem[m_ptr];
        m_ptr  <= m_ptr + 8'd1;
        m_rem  <= m_rem - 5'd1;
      end
    end
  end

  // One request from one requester, checked every cycle until the arbiter is idle again.
  task automatic run_txn(input bit is_dm, input logic [31:0] addr, input logic [2:0] size,
                         input bit rw_in, input logic [31:0] wd, input string tag);
    int unsigned nb, n, last;
    bit          e, rw;
    longint      a_end;
    int          base;
    logic [3:0]  side;
    logic        en;
    logic [8:0]  obs, expv;
    logic [63:0] exp_rd, obs_rd;
    logic [31:0] w;
    rw = is_dm ? rw_in : 1'b0;
    case (size)
      3'd0: nb = 4;  3'd1: nb = 16; 3'd2: nb = 32; 3'd3: nb = 64;
      3'd4: nb = 1;  3'd5: nb = 2;  default: nb = 0;
    endcase
    a_end = longint'(addr) + longint'(nb);
    e = (size > 3'd5)
        || (size <= 3'd3 && addr[1:0] != 2'b00)
        || (size == 3'd5 && addr[0])
        || (addr < START)
        || (a_end > longint'(START) + 1024)
        || (rw && size >= 3'd1 && size <= 3'd3);
    n    = e ? 0 : size_beats(size);
    base = int'((addr - START) >> 2);
    last = e ? 2 : (rw ? 3 : n + 2);

    if (is_dm) begin
      dm_req = 1'b1; dm_addr = addr; dm_size = size; dm_rw = rw; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr; if_size = size;
    end

    for (int unsigned k = 1; k <= last; k++) begin
      @(negedge clk);
      side = 4'b0000; en = 1'b0; exp_rd = '0;
      if (e) begin
        if (k == 1) side = 4'b1011;
      end else if (rw) begin
        if (k == 1) begin side = 4'b1000; en = 1'b1; end
        if (k == 2) side = 4'b0010;
      end else begin
        if (k == 1) begin side = 4'b1000; en = 1'b1; end
        if (k >= 2 && k <= n + 1) begin
          side = {1'b0, 1'b1, (k == n + 1), 1'b0};
          w = ref_mem[base + int'(k) - 2];
          exp_rd = is_dm ? {32'h0, w} : {w, 32'h0};
        end
      end
      expv = is_dm ? {4'b0000, side, en} : {side, 4'b0000, en};
      obs  = {if_gnt, if_rvalid, if_done, if_err, dm_gnt, dm_rvalid, dm_done, dm_err, mem_enable};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s ctl k=%0d got %b exp %b", tag, k, obs, expv);
      end
      obs_rd = {if_rdata, dm_rdata};
      checks++;
      if (obs_rd !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata k=%0d got %h exp %h", tag, k, obs_rd, exp_rd);
      end
      if (k == 1 && !e) begin
        checks++;
        if (rw) begin
          if ({mem_addr, mem_size, mem_rw, mem_din} !== {addr, size, 1'b1, wd}) begin
            errors++;
            $display("FAIL %s memw got %h/%0d/%b/%h exp %h/%0d/1/%h", tag,
                     mem_addr, mem_size, mem_rw, mem_din, addr, size, wd);
          end
        end else if ({mem_addr, mem_size, mem_rw} !== {addr, size, 1'b0}) begin
          errors++;
          $display("FAIL %s memr got %h/%0d/%b exp %h/%0d/0", tag,
                   mem_addr, mem_size, mem_rw, addr, size);
        end
      end
      if (k == 1) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end
    if (!e && rw) ref_mem[base] = wd;
  endtask

  task automatic test_reset();
    logic [140:0] v;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    v = {if_gnt, if_rvalid, if_done, if_err, dm_gnt, dm_rvalid, dm_done, dm_err, mem_enable,
         if_rdata, dm_rdata, mem_addr, mem_din, mem_size, mem_rw};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", v); end
    rst_n = 1'b1;
    @(negedge clk);
    v = {if_gnt, if_rvalid, if_done, if_err, dm_gnt, dm_rvalid, dm_done, dm_err, mem_enable,
         if_rdata, dm_rdata, mem_addr, mem_din, mem_size, mem_rw};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL idle_after_reset got %h exp 0", v); end
  endtask

  task automatic test_if_read();
    run_txn(1'b0, START, 3'b000, 1'b0, 32'h0, "if_word");
  endtask

  task automatic test_dm_burst();
    run_txn(1'b1, START + 32'h10, 3'b001, 1'b0, 32'h0, "dm_4w");
    run_txn(1'b1, START + 32'h3C0, 3'b011, 1'b0, 32'h0, "dm_16w_top");
  endtask

  task automatic test_write_read();
    run_txn(1'b1, START + 32'h20, 3'b000, 1'b1, 32'hDEAD_BEEF, "dm_wr");
    run_txn(1'b1, START + 32'h20, 3'b000, 1'b0, 32'h0, "dm_rd_back");
    checks++;
    if (ref_mem[8] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_model got %h exp deadbeef", ref_mem[8]);
    end
  endtask

  task automatic test_errors();
    run_txn(1'b0, START + 32'h2,   3'b000, 1'b0, 32'h0, "err_misalign");
    run_txn(1'b0, START + 32'h3FE, 3'b000, 1'b0, 32'h0, "err_past_end");
    run_txn(1'b0, START + 32'h400, 3'b100, 1'b0, 32'h0, "err_byte_oor");
    run_txn(1'b0, START,           3'b110, 1'b0, 32'h0, "err_size6");
    run_txn(1'b1, START + 32'h30,  3'b001, 1'b1, 32'h1111_2222, "err_wr_burst");
    run_txn(1'b1, START + 32'h5,   3'b101, 1'b0, 32'h0, "err_half_odd");
    run_txn(1'b1, START - 32'h4,   3'b000, 1'b0, 32'h0, "err_below");
    run_txn(1'b0, START + 32'h3FF, 3'b100, 1'b0, 32'h0, "ok_last_byte");
  endtask

  // Both requesters hold req high; grants must go DM x4 then IF, every n+2 = 3 cycles.
  task automatic test_back_to_back();
    int ng = 0;
    int last_c = 0;
    bit exp_dm;
    if_req = 1'b1; if_addr = START + 32'h4; if_size = 3'b000;
    dm_req = 1'b1; dm_addr = START + 32'h8; dm_size = 3'b000; dm_rw = 1'b0;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      @(negedge clk);
      if (if_rvalid) begin
        checks++;
        if (if_rdata !== ref_mem[1]) begin
          errors++; $display("FAIL b2b_if_data got %h exp %h", if_rdata, ref_mem[1]);
        end
      end
      if (dm_rvalid) begin
        checks++;
        if (dm_rdata !== ref_mem[2]) begin
          errors++; $display("FAIL b2b_dm_data got %h exp %h", dm_rdata, ref_mem[2]);
        end
      end
      if (if_gnt || dm_gnt) begin
        exp_dm = (ng % 5) != 4;
        checks++;
        if ({if_gnt, dm_gnt} !== {~exp_dm, exp_dm}) begin
          errors++;
          $display("FAIL b2b_order grant %0d got if=%b dm=%b exp dm=%b", ng, if_gnt, dm_gnt, exp_dm);
        end
        if (ng > 0) begin
          checks++;
          if (c - last_c != 3) begin
            errors++; $display("FAIL b2b_spacing grant %0d got %0d exp 3", ng, c - last_c);
          end
        end
        last_c = c;
        ng++;
        if (ng == 10) begin if_req = 1'b0; dm_req = 1'b0; end
      end
    end
    checks++;
    if (ng != 10) begin
      errors++; $display("FAIL b2b_count got %0d exp 10", ng);
      if_req = 1'b0; dm_req = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // Reset during beat 3 of an 8-word read; the orphaned burst must stall the next issue.
  task automatic test_reset_mid_burst();
    bit got = 1'b0;
    bit seen = 1'b0;
    int nrv = 0;
    int stall = 0;
    logic [140:0] v;
    dm_req = 1'b1; dm_addr = START + 32'h40; dm_size = 3'b010; dm_rw = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (dm_gnt) begin dm_req = 1'b0; got = 1'b1; end
    end
    checks++;
    if (!got) begin errors++; dm_req = 1'b0; $display("FAIL rst_burst_gnt got 0 exp 1"); end
    for (int c = 0; c < 20 && nrv < 3; c++) begin
      @(negedge clk);
      if (dm_rvalid) nrv++;
    end
    checks++;
    if (nrv != 3) begin errors++; $display("FAIL rst_burst_beats got %0d exp 3", nrv); end
    rst_n = 1'b0;
    #1;
    v = {if_gnt, if_rvalid, if_done, if_err, dm_gnt, dm_rvalid, dm_done, dm_err, mem_enable,
         if_rdata, dm_rdata, mem_addr, mem_din, mem_size, mem_rw};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL rst_async_clear got %h exp 0", v); end
    @(negedge clk);
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = START + 32'h80; if_size = 3'b000;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (if_gnt) begin
        if (mem_busy) begin
          stall++;
          checks++;
          if (mem_enable !== 1'b0) begin
            errors++; $display("FAIL rst_collide enable=%b busy=1 exp enable 0", mem_enable);
          end
        end
        if_req = 1'b0;
      end
      if (if_rvalid) begin
        seen = 1'b1;
        checks++;
        if (if_rdata !== ref_mem[32]) begin
          errors++; $display("FAIL rst_next_data got %h exp %h", if_rdata, ref_mem[32]);
        end
      end
    end
    if_req = 1'b0;
    checks++;
    if (stall == 0) begin errors++; $display("FAIL rst_stall got 0 cycles exp >=1"); end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_next_rvalid got none exp 1"); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    bit          is_dm, rw;
    logic [2:0]  size;
    logic [31:0] addr;
    int unsigned r;
    for (int t = 0; t < 40; t++) begin
      is_dm = 1'($urandom_range(0, 1));
      size  = 3'($urandom_range(0, 7));
      rw    = is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rw && (size == 3'd4 || size == 3'd5)) size = 3'd0;
      r = $urandom_range(0, 7);
      if (r == 0)      addr = START + 32'd1024 + 32'($urandom_range(0, 63));
      else if (r == 1) addr = START - 32'd1 - 32'($urandom_range(0, 7));
      else begin
        addr = START + 32'($urandom_range(0, 255)) * 32'd4;
        if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(0, 3));
      end
      run_txn(is_dm, addr, size, rw, $urandom, "rand");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    if_req = 1'b0; if_addr = '0; if_size = '0;
    dm_req = 1'b0; dm_addr = '0; dm_size = '0; dm_rw = 1'b0; dm_wdata = '0;
    rst_n = 1'b0;
    test_reset();
    test_if_read();
    test_dm_burst();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
